// File: rtl/ara_w_byte_tap.sv
// Passive tap on Ara's VLSU AXI W channel: packs strobed bytes of accepted beats into
// dense full words and queues them for a result-dump sink, with flush and loss flagging.
module ara_w_byte_tap #(
   parameter int unsigned NrLanes      = 4,
   parameter int unsigned AxiDataWidth = 64 * NrLanes / 2,
   parameter int unsigned BeWidth      = AxiDataWidth / 8,
   parameter int unsigned FifoDepth    = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       en_i,
   input  logic [AxiDataWidth-1:0]    w_data_i,
   input  logic [BeWidth-1:0]         w_strb_i,
   input  logic                       w_valid_i,
   input  logic                       w_ready_i,
   input  logic                       flush_i,
   output logic                       flush_done_o,
   output logic [AxiDataWidth-1:0]    out_data_o,
   output logic [$clog2(BeWidth):0]   out_cnt_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic                       overflow_o,
   output logic [63:0]                byte_count_o
);

   localparam int unsigned CntW  = $clog2(BeWidth) + 1;
   localparam int unsigned FillW = $clog2(2 * BeWidth) + 1;
   localparam int unsigned OccW  = $clog2(FifoDepth) + 1;

   typedef struct packed {
      logic [CntW-1:0]         cnt;
      logic [AxiDataWidth-1:0] data;
   } word_t;

   typedef enum logic [1:0] {
      F_IDLE,
      F_PEND,
      F_DONE
   } fstate_e;

   fstate_e                   state_q, state_d;
   logic [AxiDataWidth-1:0]   stage_q, stage_d;
   logic [FillW-1:0]          fill_q, fill_d;
   logic [63:0]               bc_q, bc_d;
   word_t                     mem_q [FifoDepth];
   word_t                     mem_d [FifoDepth];
   logic [OccW-1:0]           occ_q, occ_d;
   logic                      valid_q;
   logic                      ovf_q, ovf_d;
   logic                      flush_done_q;

   logic                      accept;
   logic [AxiDataWidth-1:0]   packed_c;
   logic [CntW-1:0]           pcnt;
   logic [2*AxiDataWidth-1:0] merged;
   logic [FillW-1:0]          sum;
   logic                      push_req;
   word_t                     push_word;
   logic                      pop;
   logic                      push_ok;
   logic [OccW-1:0]           wr_idx;

   assign accept = w_valid_i && w_ready_i && en_i;

   // Compact strobed lanes of the beat into the low bytes, ascending lane order.
   always_comb begin
      packed_c = '0;
      pcnt     = '0;
      for (int i = 0; i < int'(BeWidth); i++) begin
         if (w_strb_i[i]) begin
            packed_c[{pcnt[CntW-2:0], 3'b000} +: 8] = w_data_i[8*i +: 8];
            pcnt = pcnt + CntW'(1);
         end
      end
   end

   assign merged = {{AxiDataWidth{1'b0}}, stage_q}
                 | ({{AxiDataWidth{1'b0}}, packed_c} << {fill_q, 3'b000});
   assign sum    = fill_q + FillW'(pcnt);

   // Staging update, word formation and flush sequencing.
   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      fill_d    = fill_q;
      bc_d      = bc_q;
      push_req  = 1'b0;
      push_word = '0;
      if (accept) begin
         bc_d = bc_q + 64'(pcnt);
         if (sum >= FillW'(BeWidth)) begin
            push_req       = 1'b1;
            push_word.data = merged[AxiDataWidth-1:0];
            push_word.cnt  = CntW'(BeWidth);
            stage_d        = merged[2*AxiDataWidth-1:AxiDataWidth];
            fill_d         = sum - FillW'(BeWidth);
         end else begin
            stage_d = merged[AxiDataWidth-1:0];
            fill_d  = sum;
         end
      end
      case (state_q)
         F_IDLE: if (flush_i) state_d = F_PEND;
         F_PEND: begin
            if (!accept) begin
               if (fill_q != '0) begin
                  push_req       = 1'b1;
                  push_word.data = stage_q;
                  push_word.cnt  = CntW'(fill_q);
                  stage_d        = '0;
                  fill_d         = '0;
               end
               state_d = F_DONE;
            end
         end
         F_DONE:  state_d = F_IDLE;
         default: state_d = F_IDLE;
      endcase
   end

   // Shift-register FIFO: entry 0 is always the head, so outputs come straight from flops.
   always_comb begin
      pop     = valid_q && out_ready_i;
      push_ok = push_req && ((occ_q != OccW'(FifoDepth)) || pop);
      ovf_d   = ovf_q || (push_req && !push_ok);
      wr_idx  = pop ? (occ_q - OccW'(1)) : occ_q;
      mem_d   = mem_q;
      occ_d   = occ_q;
      if (pop) begin
         for (int i = 0; i < int'(FifoDepth) - 1; i++) mem_d[i] = mem_q[i+1];
         mem_d[FifoDepth-1] = '0;
      end
      if (push_ok) mem_d[wr_idx[OccW-2:0]] = push_word;
      case ({push_ok, pop})
         2'b10:   occ_d = occ_q + OccW'(1);
         2'b01:   occ_d = occ_q - OccW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= F_IDLE;
         stage_q      <= '0;
         fill_q       <= '0;
         bc_q         <= '0;
         occ_q        <= '0;
         valid_q      <= 1'b0;
         ovf_q        <= 1'b0;
         flush_done_q <= 1'b0;
         for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         stage_q      <= stage_d;
         fill_q       <= fill_d;
         bc_q         <= bc_d;
         occ_q        <= occ_d;
         valid_q      <= (occ_d != '0);
         ovf_q        <= ovf_d;
         flush_done_q <= (state_q == F_DONE);
         for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= mem_d[i];
      end
   end

   assign out_data_o   = mem_q[0].data;
   assign out_cnt_o    = mem_q[0].cnt;
   assign out_valid_o  = valid_q;
   assign overflow_o   = ovf_q;
   assign byte_count_o = bc_q;
   assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_ara_w_byte_tap.sv
// Bench for ara_w_byte_tap: byte-queue reference model checked every cycle, plus literal pins.
module tb_ara_w_byte_tap;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         en_i;
   logic [127:0] w_data_i;
   logic [15:0]  w_strb_i;
   logic         w_valid_i;
   logic         w_ready_i;
   logic         flush_i;
   logic         flush_done_o;
   logic [127:0] out_data_o;
   logic [4:0]   out_cnt_o;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         overflow_o;
   logic [63:0]  byte_count_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit run   = 1'b0;

   ara_w_byte_tap dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .w_data_i     (w_data_i),
      .w_strb_i     (w_strb_i),
      .w_valid_i    (w_valid_i),
      .w_ready_i    (w_ready_i),
      .flush_i      (flush_i),
      .flush_done_o (flush_done_o),
      .out_data_o   (out_data_o),
      .out_cnt_o    (out_cnt_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .overflow_o   (overflow_o),
      .byte_count_o (byte_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference model: bytes as a plain queue, words as a queue capped at 8 entries.
   typedef struct {
      logic [127:0] d;
      int           c;
   } mw_t;

   byte unsigned    m_stage[$];
   mw_t             m_fifo[$];
   bit              m_ovf;
   longint unsigned m_bc;
   int              m_fs;
   bit              m_done;
   bit              m_acc, m_pop, m_has;
   int              m_ofs;
   mw_t             m_w;

   function automatic mw_t take(input int n);
      mw_t w;
      w.d = '0;
      w.c = n;
      for (int k = 0; k < n; k++) w.d[8*k +: 8] = m_stage.pop_front();
      return w;
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_stage.delete();
         m_fifo.delete();
         m_ovf  = 0;
         m_bc   = 0;
         m_fs   = 0;
         m_done = 0;
      end else begin
         m_ofs = m_fs;
         m_pop = (m_fifo.size() > 0) && out_ready_i;
         m_acc = w_valid_i && w_ready_i && en_i;
         m_has = 0;
         if (m_acc) begin
            for (int i = 0; i < 16; i++) if (w_strb_i[i]) m_stage.push_back(w_data_i[8*i +: 8]);
            m_bc += longint'($countones(w_strb_i));
            if (m_stage.size() >= 16) begin
               m_w   = take(16);
               m_has = 1;
            end
         end
         if (m_ofs == 1 && !m_acc && m_stage.size() > 0) begin
            m_w   = take(m_stage.size());
            m_has = 1;
         end
         if (m_ofs == 0)      m_fs = flush_i ? 1 : 0;
         else if (m_ofs == 1) m_fs = m_acc ? 1 : 2;
         else                 m_fs = 0;
         m_done = (m_ofs == 2);
         if (m_pop) void'(m_fifo.pop_front());
         if (m_has) begin
            if (m_fifo.size() < 8) m_fifo.push_back(m_w);
            else                   m_ovf = 1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (run) begin
         chk("valid", 128'(out_valid_o), 128'(m_fifo.size() > 0));
         chk("data", out_data_o, (m_fifo.size() > 0) ? m_fifo[0].d : 128'h0);
         chk("cnt", 128'(out_cnt_o), (m_fifo.size() > 0) ? 128'(m_fifo[0].c) : 128'h0);
         chk("overflow", 128'(overflow_o), 128'(m_ovf));
         chk("byte_count", 128'(byte_count_o), 128'(m_bc));
         chk("flush_done", 128'(flush_done_o), 128'(m_done));
      end
   end

   function automatic logic [127:0] seq(input logic [7:0] base);
      logic [127:0] d;
      for (int i = 0; i < 16; i++) d[8*i +: 8] = base + 8'(i);
      return d;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic beat(input logic [127:0] d, input logic [15:0] s);
      w_data_i  = d;
      w_strb_i  = s;
      w_valid_i = 1'b1;
      step(1);
      w_valid_i = 1'b0;
      w_strb_i  = '0;
      w_data_i  = '0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      en_i        = 1'b1;
      w_data_i    = '0;
      w_strb_i    = '0;
      w_valid_i   = 1'b0;
      w_ready_i   = 1'b1;
      flush_i     = 1'b0;
      out_ready_i = 1'b1;
      #2 run = 1'b1;
      step(3);
      chk("reset_valid", 128'(out_valid_o), 128'h0);
      chk("reset_bc", 128'(byte_count_o), 128'h0);
      rst_ni = 1'b1;

      // T1: four full beats
      beat(seq(8'h00), 16'hFFFF);
      chk("t1_word0", out_data_o, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("t1_cnt0", 128'(out_cnt_o), 128'd16);
      for (int k = 1; k < 4; k++) beat(seq(8'(16 * k)), 16'hFFFF);
      step(3);
      chk("t1_bc", 128'(byte_count_o), 128'd64);

      // Valid without ready is not a transfer
      w_ready_i = 1'b0;
      beat(seq(8'hA0), 16'hFFFF);
      w_ready_i = 1'b1;
      step(1);
      chk("noready_bc", 128'(byte_count_o), 128'd64);

      // T2: sparse strobes across two beats
      beat(seq(8'h10), 16'h00F0);
      chk("t2_nopush", 128'(out_valid_o), 128'h0);
      beat(seq(8'h20), 16'hFF0F);
      chk("t2_word", out_data_o, 128'h2F2E2D2C2B2A29282322212017161514);
      chk("t2_cnt", 128'(out_cnt_o), 128'd16);
      step(2);

      // T3: partial word via flush
      beat(seq(8'h30), 16'h0007);
      flush_i = 1'b1;
      step(1);
      flush_i = 1'b0;
      step(1);
      chk("t3_cnt", 128'(out_cnt_o), 128'd3);
      chk("t3_data", out_data_o, 128'h323130);
      chk("t3_done_early", 128'(flush_done_o), 128'h0);
      step(1);
      chk("t3_done", 128'(flush_done_o), 128'h1);
      step(1);
      chk("t3_done_drop", 128'(flush_done_o), 128'h0);

      // T4: overflow with sink stalled, then pop+push on a full FIFO
      out_ready_i = 1'b0;
      for (int k = 0; k < 9; k++) beat(seq(8'(64 + 16 * k)), 16'hFFFF);
      chk("t4_ovf", 128'(overflow_o), 128'h1);
      chk("t4_head", out_data_o, seq(8'h40));
      out_ready_i = 1'b1;
      beat(seq(8'h77), 16'hFFFF);
      step(12);
      chk("t4_empty", 128'(out_valid_o), 128'h0);

      // T5: disabled beats ignored; flush with empty staging; repeated flush ignored
      en_i = 1'b0;
      for (int k = 0; k < 3; k++) beat(seq(8'hE0), 16'hFFFF);
      chk("t5_bc", 128'(byte_count_o), 128'd243);
      chk("t5_nopush", 128'(out_valid_o), 128'h0);
      flush_i = 1'b1;
      step(3);
      flush_i = 1'b0;
      chk("t5_done", 128'(flush_done_o), 128'h1);
      chk("t5_noword", 128'(out_valid_o), 128'h0);
      step(1);
      chk("t5_done_once", 128'(flush_done_o), 128'h0);
      step(2);
      en_i = 1'b1;

      // T6: flush coincident with beats keeps PEND
      flush_i = 1'b1;
      beat(seq(8'h50), 16'h0003);
      flush_i = 1'b0;
      beat(seq(8'h60), 16'h0003);
      chk("t6_pend", 128'(out_valid_o), 128'h0);
      step(1);
      chk("t6_cnt", 128'(out_cnt_o), 128'd4);
      chk("t6_data", out_data_o, 128'h61605150);
      step(3);

      // Reset mid-stream
      out_ready_i = 1'b0;
      beat(seq(8'h90), 16'hFFFF);
      beat(seq(8'hA0), 16'hFFFF);
      beat(seq(8'hB0), 16'h0005);
      #3 rst_ni = 1'b0;
      #1;
      chk("rst_valid", 128'(out_valid_o), 128'h0);
      chk("rst_data", out_data_o, 128'h0);
      chk("rst_cnt", 128'(out_cnt_o), 128'h0);
      chk("rst_bc", 128'(byte_count_o), 128'h0);
      chk("rst_ovf", 128'(overflow_o), 128'h0);
      step(2);
      rst_ni      = 1'b1;
      out_ready_i = 1'b1;
      beat(seq(8'hC0), 16'h8001);
      beat(seq(8'hD0), 16'hFFFF);
      step(3);
      chk("post_rst_bc", 128'(byte_count_o), 128'd18);

      run = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
